cbd_sampler_stream: RTL and testbench

//  Streaming centered-binomial (CBD) sampler for Kyber secret/error polynomials. Consumes PRF
//  (SHAKE-256) output as a valid/ready bit stream, converts 2*eta bits per coefficient to a value
//  in Z_q, and writes LANES packed coefficients per cycle into polynomial RAM from base_addr.
//  Eta (2 or 3) is selected per run; the input side tolerates arbitrary backpressure and gaps.

---
 rtl/kyber_cbd_pkg.sv | 13 +
 rtl/cbd_coef.sv | 15 +
 rtl/cbd_sampler_stream.sv | 84 ++++++++
 tb/tb_cbd_sampler_stream.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/kyber_cbd_pkg.sv
// kyber_cbd_pkg: shared constants and state encoding for the streaming CBD sampler
package kyber_cbd_pkg;
  localparam int Q = 3329;
  localparam int COEF_W = 12;
  localparam int N = 256;
  localparam int LANES = 8;
  localparam int IN_W = 64;
  localparam int ADDR_W = 10;
  localparam int BUF_W = 2 * IN_W;
  localparam logic ETA2 = 1'b0;
  localparam logic ETA3 = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cbd_coef.sv
// cbd_coef: one centered-binomial coefficient in Z_q from 2*eta stream bits
module cbd_coef
  import kyber_cbd_pkg::*;
(
  input  logic [5:0]        bits,
  input  logic              eta_sel,
  output logic [COEF_W-1:0] coef
);
  logic [1:0] a, b;
  always_comb begin
    a = 2'(bits[0]) + 2'(bits[1]) + (eta_sel == ETA3 ? 2'(bits[2]) : 2'd0);
    b = eta_sel == ETA3 ? 2'(bits[3]) + 2'(bits[4]) + 2'(bits[5]) : 2'(bits[2]) + 2'(bits[3]);
    coef = a >= b ? COEF_W'(a - b) : COEF_W'(Q) + COEF_W'(a) - COEF_W'(b);
  end
endmodule

// File: rtl/cbd_sampler_stream.sv
// cbd_sampler_stream: PRF bit stream -> CBD coefficients, LANES per RAM word from base_addr
module cbd_sampler_stream
  import kyber_cbd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    eta_sel,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [LANES*COEF_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done
);
  state_t state, state_n;
  logic [BUF_W-1:0] bit_buf;
  logic [7:0] cnt, keep;
  logic [4:0] beats, word_cnt, beat_total;
  logic [5:0] need;
  logic eta3, emit, accept;
  logic [ADDR_W-1:0] base;
  logic [LANES*COEF_W-1:0] coefs;
  assign need = eta3 ? 6'd48 : 6'd32;
  assign beat_total = eta3 ? 5'd24 : 5'd16;
  assign in_ready = state == RUN && cnt <= 8'(BUF_W - IN_W) && beats < beat_total;
  assign emit = state == RUN && cnt >= 8'(need);
  assign accept = in_valid && in_ready;
  assign keep = cnt - (emit ? 8'(need) : 8'd0);
  assign busy = state != IDLE;
  assign done = state == DONE;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cbd_coef u_coef (
      .bits   (eta3 ? bit_buf[6*g +: 6] : {2'b00, bit_buf[4*g +: 4]}),
      .eta_sel(eta3),
      .coef   (coefs[g*COEF_W +: COEF_W])
    );
  end
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN ? (emit && word_cnt == 5'(N / LANES - 1) ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // New beats land directly above the bits that survive this cycle's consumption
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      bit_buf <= '0;
      cnt <= '0;
      beats <= '0;
      word_cnt <= '0;
      eta3 <= 1'b0;
      base <= '0;
    end else begin
      wr_en <= emit;
      if (emit) begin
        wr_data <= coefs;
        wr_addr <= base + ADDR_W'(word_cnt);
        word_cnt <= word_cnt + 5'd1;
      end
      if (state == IDLE && start) begin
        eta3 <= eta_sel;
        base <= base_addr;
        bit_buf <= '0;
        cnt <= '0;
        beats <= '0;
        word_cnt <= '0;
      end else begin
        bit_buf <= (bit_buf >> (emit ? need : 6'd0)) | (accept ? BUF_W'(in_data) << keep : '0);
        cnt <= keep + (accept ? 8'(IN_W) : 8'd0);
        if (accept) beats <= beats + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_cbd_sampler_stream.sv
// tb_cbd_sampler_stream: directed and randomized runs checked against a byte-level CBD model
module tb_cbd_sampler_stream;
  logic clk = 1'b0;
  logic rst, start, eta_sel, in_valid, in_ready, wr_en, busy, done;
  logic [9:0] base_addr, wr_addr;
  logic [63:0] in_data;
  logic [95:0] wr_data;
  byte unsigned stream[192];
  logic [95:0] wd[32];
  logic [9:0] wa[32];
  int nwr, ndone, beats, vectors, fails;

  cbd_sampler_stream dut (
    .clk(clk), .rst(rst), .start(start), .eta_sel(eta_sel), .base_addr(base_addr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bit_of(int j);
    return (stream[j / 8] >> (j % 8)) & 1;
  endfunction

  function automatic int model(bit e3, int i);
    int eta = e3 ? 3 : 2;
    int a = 0, b = 0;
    for (int j = 0; j < eta; j++) begin
      a += bit_of(2 * eta * i + j);
      b += bit_of(2 * eta * i + eta + j);
    end
    return (a - b + 3329) % 3329;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 192; i++)
      stream[i] = mode == 0 ? 8'h00 : mode == 1 ? 8'hFF : 8'($urandom);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_wr_en"}, 96'(wr_en), 96'd0);
    chk({tag, "_busy"}, 96'(busy), 96'd0);
    chk({tag, "_done"}, 96'(done), 96'd0);
    chk({tag, "_in_ready"}, 96'(in_ready), 96'd0);
  endtask

  task automatic run(input bit e3, input logic [9:0] base, input bit gaps, input bit hold,
                     input bit probe, input int abort_at);
    int total = e3 ? 24 : 16;
    logic acc;
    logic [95:0] expw;
    @(negedge clk);
    eta_sel = e3; base_addr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0; eta_sel = ~e3; base_addr = 10'h2AA;
    nwr = 0; ndone = 0; beats = 0;
    for (int cyc = 0; cyc < 600 && ndone == 0; cyc++) begin
      if (wr_en) begin
        if (nwr < 32) begin wd[nwr] = wr_data; wa[nwr] = wr_addr; end
        nwr++;
      end
      if (done) ndone++;
      if (abort_at > 0 && nwr == abort_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        idle_checks("abort");
        rst = 1'b0;
        return;
      end
      start = probe && cyc == 5;
      in_valid = (hold || beats < total) && (!gaps || $urandom_range(0, 2) != 0);
      for (int k = 0; k < 8; k++)
        in_data[8*k +: 8] = beats < total ? stream[beats * 8 + k] : 8'hA5;
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) beats++;
    end
    start = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    idle_checks("post");
    chk("writes", 96'(nwr), 96'd32);
    chk("done_pulses", 96'(ndone), 96'd1);
    chk("beats", 96'(beats), 96'(total));
    if (hold) chk("cnt_end", 96'(dut.cnt), 96'd0);
    for (int w = 0; w < 32; w++) begin
      for (int l = 0; l < 8; l++) expw[12*l +: 12] = 12'(model(e3, w * 8 + l));
      chk($sformatf("addr%0d", w), 96'(wa[w]), 96'(10'(base + 10'(w))));
      chk($sformatf("data%0d", w), wd[w], expw);
    end
  endtask

  initial begin
    vectors = 0; fails = 0;
    rst = 1'b1; start = 1'b0; eta_sel = 1'b0; base_addr = '0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    idle_checks("reset");
    chk("reset_wr_data", wr_data, 96'd0);
    chk("reset_wr_addr", 96'(wr_addr), 96'd0);
    rst = 1'b0;
    fill(0);
    run(1'b0, 10'h040, 1'b0, 1'b0, 1'b0, 0);
    chk("zero_word0", wd[0], 96'd0);
    fill(0); stream[0] = 8'h03; stream[1] = 8'h0C;
    run(1'b0, 10'h100, 1'b0, 1'b0, 1'b0, 0);
    chk("e2_coef0", 96'(wd[0][11:0]), 96'd2);
    chk("e2_coef1", 96'(wd[0][23:12]), 96'd0);
    chk("e2_coef2", 96'(wd[0][35:24]), 96'd3327);
    fill(1);
    run(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 0);
    chk("e3_ff_word31", wd[31], 96'd0);
    fill(1); stream[0] = 8'h07; stream[1] = 8'h00;
    run(1'b1, 10'h080, 1'b0, 1'b0, 1'b0, 0);
    chk("e3_coef0_3", 96'(wd[0][11:0]), 96'd3);
    fill(0); stream[0] = 8'h38;
    run(1'b1, 10'h080, 1'b0, 1'b0, 1'b0, 0);
    chk("e3_coef0_3326", 96'(wd[0][11:0]), 96'd3326);
    fill(2);
    run(1'b0, 10'h3F0, 1'b1, 1'b0, 1'b0, 0);
    fill(2);
    run(1'b1, 10'h3F0, 1'b1, 1'b0, 1'b0, 0);
    fill(2);
    run(1'b1, 10'h200, 1'b1, 1'b0, 1'b1, 0);
    fill(2);
    run(1'b0, 10'h010, 1'b0, 1'b0, 1'b0, 10);
    run(1'b0, 10'h010, 1'b1, 1'b0, 1'b0, 0);
    fill(2);
    run(1'b1, 10'h123, 1'b0, 1'b1, 1'b0, 0);
    fill(2);
    run(1'b0, 10'h321, 1'b0, 1'b1, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
